// File: rtl/hex_msg_sequencer_if.sv
// hex_msg_sequencer_if: board-side bundle between the SW/KEY inputs and
// the six HEX digit outputs of the message sequencer.
// master = board/test side that drives button, switches and message slots.
// slave  = the sequencer itself.
interface hex_msg_sequencer_if #(
  parameter int NUM_MSG = 4
);
  localparam int IDX_W = $clog2(NUM_MSG);

  logic                   step_n;
  logic                   auto_en;
  logic [NUM_MSG*24-1:0]  msg_data;
  logic [NUM_MSG-1:0]     msg_valid;
  logic [IDX_W-1:0]       cur_idx;
  logic                   showing;
  logic [7:0]             HEX5;
  logic [7:0]             HEX4;
  logic [7:0]             HEX3;
  logic [7:0]             HEX2;
  logic [7:0]             HEX1;
  logic [7:0]             HEX0;

  modport master (
    output step_n, auto_en, msg_data, msg_valid,
    input  cur_idx, showing, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
  );

  modport slave (
    input  step_n, auto_en, msg_data, msg_valid,
    output cur_idx, showing, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
  );
endinterface

// File: rtl/hex_msg_sequencer.sv
// hex_msg_sequencer: picks which of NUM_MSG six-digit messages drives
// HEX5..HEX0, advancing round-robin on a dwell timer or a debounced
// KEY press, with a blank gap between messages.
// Optional feature macro: HEX_SEQ_DATE_DP_EN -- when defined, the decimal
// points of HEX4 and HEX2 are lit while a message is shown (MM.DD.YY).
module hex_msg_sequencer #(
  parameter int NUM_MSG      = 4,
  parameter int DWELL_CYC    = 100_000_000,
  parameter int BLANK_CYC    = 10_000_000,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic                MAX10_CLK1_50,
  input  logic                reset_n,
  hex_msg_sequencer_if.slave  bus
);

  localparam int IDX_W   = $clog2(NUM_MSG);
  localparam int CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [7:0] HEX_BLANK = 8'hFF;

`ifdef HEX_SEQ_DATE_DP_EN
  localparam logic [5:0] SHOW_DP_N = 6'b101011;
`else
  localparam logic [5:0] SHOW_DP_N = 6'b111111;
`endif

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  logic [1:0]        r_stepSync;
  logic              r_dbLevel;
  logic [DB_W-1:0]   r_dbCnt;
  logic              r_stepPulse;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_curIdx;
  logic              r_showing;
  logic [5:0][7:0]   r_hex;

  logic              w_anyValid;
  logic              w_curValid;
  logic              w_advReq;
  logic [IDX_W-1:0]  w_lowIdx;
  logic [IDX_W-1:0]  w_upIdx;
  logic              w_upFound;
  logic [IDX_W-1:0]  w_nextIdx;
  logic [IDX_W-1:0]  w_selIdx;
  logic [23:0]       w_selData;
  logic [5:0][7:0]   w_showHex;

  // Synchronize the raw KEY, debounce it, and emit one pulse per accepted press.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_stepSync  <= 2'b11;
      r_dbLevel   <= 1'b1;
      r_dbCnt     <= '0;
      r_stepPulse <= 1'b0;
    end else begin
      r_stepSync  <= {r_stepSync[0], bus.step_n};
      r_stepPulse <= 1'b0;
      if (r_stepSync[1] == r_dbLevel) begin
        r_dbCnt <= '0;
      end else if (r_dbCnt == DB_LAST) begin
        r_dbLevel   <= r_stepSync[1];
        r_dbCnt     <= '0;
        r_stepPulse <= r_dbLevel & ~r_stepSync[1];
      end else begin
        r_dbCnt <= r_dbCnt + DB_W'(1);
      end
    end
  end

  // Lowest valid slot and whether the current slot is still valid.
  always_comb begin
    w_anyValid = |bus.msg_valid;
    w_lowIdx   = '0;
    w_curValid = 1'b0;
    for (int k = NUM_MSG - 1; k >= 0; k--) begin
      if (bus.msg_valid[k]) begin
        w_lowIdx = IDX_W'(k);
      end
      if (r_curIdx == IDX_W'(k)) begin
        w_curValid = bus.msg_valid[k];
      end
    end
  end

  // Round-robin successor: first valid slot above cur_idx, else wrap to the lowest.
  always_comb begin
    w_upIdx   = '0;
    w_upFound = 1'b0;
    for (int k = NUM_MSG - 1; k >= 0; k--) begin
      if (bus.msg_valid[k] && (IDX_W'(k) > r_curIdx)) begin
        w_upIdx   = IDX_W'(k);
        w_upFound = 1'b1;
      end
    end
    w_nextIdx = w_upFound ? w_upIdx : w_lowIdx;
  end

  // Slot whose digits will be loaded on this edge, depending on where we come from.
  always_comb begin
    case (r_state)
      ST_IDLE:  w_selIdx = w_lowIdx;
      ST_BLANK: w_selIdx = w_nextIdx;
      default:  w_selIdx = r_curIdx;
    endcase
  end

  // Fetch the selected slot and decode its six nibbles into segment bytes.
  always_comb begin
    w_selData = '0;
    for (int k = 0; k < NUM_MSG; k++) begin
      if (w_selIdx == IDX_W'(k)) begin
        w_selData = bus.msg_data[24*k +: 24];
      end
    end
    w_showHex = '0;
    for (int d = 0; d < 6; d++) begin
      w_showHex[d] = {SHOW_DP_N[d], hexToSeg(w_selData[4*d +: 4])};
    end
  end

  // A step and a dwell expiry in the same cycle collapse into one request.
  always_comb begin
    w_advReq = r_stepPulse | (bus.auto_en & (r_cnt == DWELL_LAST));
  end

  // Display scheduler: IDLE until a slot is valid, then SHOW/BLANK alternation.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_curIdx  <= '0;
      r_showing <= 1'b0;
      r_hex     <= {6{HEX_BLANK}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyValid) begin
            r_state   <= ST_SHOW;
            r_curIdx  <= w_lowIdx;
            r_showing <= 1'b1;
            r_hex     <= w_showHex;
            r_cnt     <= '0;
          end
        end
        ST_SHOW: begin
          if (!w_anyValid) begin
            r_state   <= ST_IDLE;
            r_showing <= 1'b0;
            r_hex     <= {6{HEX_BLANK}};
            r_cnt     <= '0;
          end else if (!w_curValid || w_advReq) begin
            r_state   <= ST_BLANK;
            r_showing <= 1'b0;
            r_hex     <= {6{HEX_BLANK}};
            r_cnt     <= '0;
          end else begin
            r_hex <= w_showHex;
            if (r_cnt != DWELL_LAST) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_BLANK: begin
          if (!w_anyValid) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == BLANK_LAST) begin
            r_state   <= ST_SHOW;
            r_curIdx  <= w_nextIdx;
            r_showing <= 1'b1;
            r_hex     <= w_showHex;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_showing <= 1'b0;
          r_hex     <= {6{HEX_BLANK}};
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.cur_idx = r_curIdx;
  assign bus.showing = r_showing;
  assign bus.HEX5    = r_hex[5];
  assign bus.HEX4    = r_hex[4];
  assign bus.HEX3    = r_hex[3];
  assign bus.HEX2    = r_hex[2];
  assign bus.HEX1    = r_hex[1];
  assign bus.HEX0    = r_hex[0];

endmodule
